button_conditioner: RTL
=======================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- PRESCALE, 25000, clk cycles per sample tick (1 ms at 25 MHz).
- DEB_TICKS, 8, consecutive differing ticks needed to accept a new level.
- REPEAT_DELAY, 400, ticks from press to first repeat.
- REPEAT_RATE, 50, ticks between later repeats.
- REPEAT_MASK, 6'b011011, channels with auto-repeat (left/right only).
- ACTIVE_LOW, 0, 1 inverts all pins before synchronisation.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock.
- nRst, in, 1, asynchronous active-low reset.
- en, in, 1, design enable.
- btn_pin, in, 6, raw pins: [0] p1 left, [1] p1 right, [2] p1 select, [3] p2 left, [4] p2 right, [5] p2 select.
- btn_level, out, 6, debounced level, 1 = pressed.
- btn_press, out, 6, one-cycle pulse on an accepted press.
- btn_release, out, 6, one-cycle pulse on an accepted release.
- btn_repeat, out, 6, one-cycle pulse on a press and on each auto-repeat.
REQ-003 There SHALL be one clock (clk) and one reset (nRst); reset SHALL be asynchronous and active-low.

Function
REQ-004 Each pin SHALL pass through a 2-flop synchroniser before any other logic uses it.
REQ-005 A shared prescaler SHALL count 0..PRESCALE-1 and assert tick for one cycle when it wraps to 0.
- The first tick SHALL occur PRESCALE cycles after reset release.
REQ-006 Per channel, on each tick:
- If the synchronised input differs from btn_level, the debounce counter SHALL increment.
- Otherwise the counter SHALL clear.
REQ-007 When the debounce counter reaches DEB_TICKS, btn_level SHALL toggle on that same edge and the counter SHALL clear.
REQ-008 A glitch that recovers before DEB_TICKS consecutive ticks SHALL leave btn_level and all pulses unchanged.
REQ-009 btn_press SHALL be 1 for exactly the first cycle in which btn_level reads 1 after reading 0; btn_release likewise for the 1->0 transition.
REQ-010 btn_repeat SHALL pulse in the same cycle as btn_press on every channel.
REQ-011 For REPEAT_MASK channels, a press SHALL load the repeat counter with REPEAT_DELAY.
- Each tick while btn_level=1 SHALL decrement the counter.
- On reaching 0, btn_repeat SHALL pulse for one cycle and the counter SHALL reload with REPEAT_RATE.
REQ-012 Unmasked channels SHALL never emit btn_repeat except with btn_press.
REQ-013 A release SHALL cancel any pending repeat. btn_repeat SHALL NOT assert in the release cycle or afterwards until the next press.
REQ-014 If a debounce toggle and a repeat expiry fall on the same tick, the toggle SHALL win: a release produces no repeat pulse.
REQ-015 Counter widths SHALL be ceil(log2(max+1)) of their parameter. Counters SHALL saturate, never wrap.
REQ-016 While en=0:
- The prescaler, debounce counters and repeat counters SHALL be held at 0.
- btn_level SHALL be forced to 0, with no press/release/repeat pulses.
- The synchroniser SHALL keep running.
REQ-017 When en rises, buttons already held SHALL be debounced from scratch and produce a normal press after DEB_TICKS ticks.
REQ-018 All outputs SHALL be registered; there SHALL be no combinational path from btn_pin to any output.

Reset
REQ-019 Asserting nRst SHALL clear immediately: synchroniser flops, prescaler, all counters, btn_level, btn_press, btn_release and btn_repeat (all 0).
REQ-020 Reset asserted mid-debounce or mid-repeat SHALL discard the partial count. After release, behaviour SHALL match a fresh start.
REQ-021 ACTIVE_LOW=1 SHALL reset the synchroniser to the released (0 after inversion) level, so no spurious press occurs after reset.

Structure
REQ-022 Button index constants (BTN_P1_LEFT..BTN_P2_SELECT) and parameter defaults SHALL live in the shared package pong_pkg.
REQ-023 Per-channel logic SHALL be one sub-module, button_channel, instantiated 6 times.
- button_channel SHALL contain the synchroniser, debounce counter, repeat counter and pulse generation.
- The prescaler SHALL stay in button_conditioner and be shared.

Verification (bench params: PRESCALE=4, DEB_TICKS=3, REPEAT_DELAY=5, REPEAT_RATE=2)
REQ-024 Clean press: hold btn_pin[0]=1.
- btn_level[0] rises on the 3rd tick after the synchronised value changes.
- btn_press[0] and btn_repeat[0] are high for 1 cycle; other bits stay 0.
REQ-025 Glitch: pulse btn_pin[2] high for 6 cycles (spanning at most 2 ticks) -> btn_level[2] and all pulses stay 0.
REQ-026 Auto-repeat: hold btn_pin[1] for 40 ticks.
- btn_repeat[1] pulses at press, then 5 ticks later, then every 2 ticks.
- Holding btn_pin[2] the same way gives only the press pulse.
REQ-027 Release: release btn_pin[1] mid-repeat.
- btn_release[1] pulses once 3 ticks after the change.
- No btn_repeat[1] in or after that cycle.
REQ-028 en/reset: drop en to 0 while btn 4 is held -> btn_level[4]=0 within 1 cycle and no pulses.
- Raising en again -> press pulse 3 ticks later.
- Asserting nRst mid-count -> all outputs 0 asynchronously, with no pulse after release while the pin is low.

Source files
------------

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared button indices, conditioner defaults and counter sizing helper
package pong_pkg;

    localparam int unsigned NUM_BTN       = 6;
    localparam int unsigned BTN_P1_LEFT   = 0;
    localparam int unsigned BTN_P1_RIGHT  = 1;
    localparam int unsigned BTN_P1_SELECT = 2;
    localparam int unsigned BTN_P2_LEFT   = 3;
    localparam int unsigned BTN_P2_RIGHT  = 4;
    localparam int unsigned BTN_P2_SELECT = 5;

    localparam int unsigned PRESCALE_DEF     = 25000;
    localparam int unsigned DEB_TICKS_DEF    = 8;
    localparam int unsigned REPEAT_DELAY_DEF = 400;
    localparam int unsigned REPEAT_RATE_DEF  = 50;
    localparam logic [NUM_BTN-1:0] REPEAT_MASK_DEF = 6'b011011;
    localparam bit ACTIVE_LOW_DEF = 1'b0;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_channel.sv
// rtl/button_channel.sv - one button: synchroniser, debounce, auto-repeat and edge pulses
module button_channel
    import pong_pkg::*;
#(
    parameter int unsigned DEB_TICKS    = DEB_TICKS_DEF,
    parameter int unsigned REPEAT_DELAY = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_RATE  = REPEAT_RATE_DEF,
    parameter bit          REPEAT_EN    = 1'b0,
    parameter bit          ACTIVE_LOW   = ACTIVE_LOW_DEF
) (
    input  logic clk,
    input  logic nRst,
    input  logic en,
    input  logic tick,
    input  logic pin,
    output logic level,
    output logic press,
    output logic rls,
    output logic rpt
);

    localparam int unsigned DW = cnt_width(DEB_TICKS);
    localparam int unsigned RW = cnt_width((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS - 1);
    localparam logic [RW-1:0] REP_DELAY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_RATE  = RW'(REPEAT_RATE);
    localparam logic [RW-1:0] REP_ONE   = RW'(1);

    logic          sync1_q, sync1_d, sync2_q, sync2_d;
    logic          level_q, level_d, press_q, press_d, rls_q, rls_d, rpt_q, rpt_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [RW-1:0] rep_q, rep_d;
    logic          toggle;

    always_comb begin
        // Inversion happens before the first flop so reset 0 always means released.
        sync1_d = pin ^ ACTIVE_LOW;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        rep_d   = rep_q;
        level_d = level_q;
        press_d = 1'b0;
        rls_d   = 1'b0;
        rpt_d   = 1'b0;
        toggle  = 1'b0;
        if (!en) begin
            deb_d   = '0;
            rep_d   = '0;
            level_d = 1'b0;
        end else if (tick) begin
            if (sync2_q != level_q) begin
                if (deb_q >= DEB_LAST) toggle = 1'b1;
                else                   deb_d  = deb_q + 1'b1;
            end else begin
                deb_d = '0;
            end
            // An accepted level change takes priority over a repeat expiring on the same tick.
            if (toggle) begin
                deb_d   = '0;
                level_d = ~level_q;
                press_d = ~level_q;
                rpt_d   = ~level_q;
                rls_d   = level_q;
                rep_d   = (!level_q && REPEAT_EN) ? REP_DELAY : '0;
            end else if (level_q && REPEAT_EN) begin
                if (rep_q <= REP_ONE) begin
                    rpt_d = 1'b1;
                    rep_d = REP_RATE;
                end else begin
                    rep_d = rep_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= '0;
            rep_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rls_q   <= 1'b0;
            rpt_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            rep_q   <= rep_d;
            level_q <= level_d;
            press_q <= press_d;
            rls_q   <= rls_d;
            rpt_q   <= rpt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;
    assign rls   = rls_q;
    assign rpt   = rpt_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - shared sample-tick prescaler driving six button channels
module button_conditioner
    import pong_pkg::*;
#(
    parameter int unsigned          PRESCALE     = PRESCALE_DEF,
    parameter int unsigned          DEB_TICKS    = DEB_TICKS_DEF,
    parameter int unsigned          REPEAT_DELAY = REPEAT_DELAY_DEF,
    parameter int unsigned          REPEAT_RATE  = REPEAT_RATE_DEF,
    parameter logic [NUM_BTN-1:0]   REPEAT_MASK  = REPEAT_MASK_DEF,
    parameter bit                   ACTIVE_LOW   = ACTIVE_LOW_DEF
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic               en,
    input  logic [NUM_BTN-1:0] btn_pin,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat
);

    localparam int unsigned PW = cnt_width(PRESCALE - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic          tick_q, tick_d;

    always_comb begin
        pre_d  = pre_q + 1'b1;
        tick_d = 1'b0;
        if (!en) begin
            pre_d = '0;
        end else if (pre_q >= PRE_LAST) begin
            pre_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        button_channel #(
            .DEB_TICKS   (DEB_TICKS),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE),
            .REPEAT_EN   (REPEAT_MASK[i]),
            .ACTIVE_LOW  (ACTIVE_LOW)
        ) u_ch (
            .clk  (clk),
            .nRst (nRst),
            .en   (en),
            .tick (tick_q),
            .pin  (btn_pin[i]),
            .level(btn_level[i]),
            .press(btn_press[i]),
            .rls  (btn_release[i]),
            .rpt  (btn_repeat[i])
        );
    end

endmodule
